// File: rtl/reg_file_pkg.sv
// Shared constants for the eight-entry register bank and its read ports.
package reg_file_pkg;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = 3;

    localparam logic [RF_WIDTH-1:0] RF_RESET_VAL = '0;

endpackage

// File: rtl/rf_rd_port.sv
// One ready/valid read port: grant logic, write-first forwarding mux and a
// registered output stage that freezes while the consumer stalls.
module rf_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] regData_i,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    output logic             gnt_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             gnt;

    // Gating with rst_n keeps the grant low for the whole reset window.
    always_comb begin
        gnt     = rst_n && req_i && (!valid_q || ready_i);
        valid_d = valid_q;
        data_d  = data_q;
        if (gnt) begin
            valid_d = 1'b1;
            data_d  = (wrEn_i && (wrAddr_i == addr_i)) ? wrData_i : regData_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign gnt_o   = gnt;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/reg_file_rd.sv
// Register bank storage with an enabled write path and two independent
// read ports built from rf_rd_port.
module reg_file_rd
    import reg_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd0_req,
    input  logic [AW-1:0]    rd0_addr,
    output logic             rd0_gnt,
    output logic             rd0_valid,
    output logic [WIDTH-1:0] rd0_data,
    input  logic             rd0_ready,
    input  logic             rd1_req,
    input  logic [AW-1:0]    rd1_addr,
    output logic             rd1_gnt,
    output logic             rd1_valid,
    output logic [WIDTH-1:0] rd1_data,
    input  logic             rd1_ready
);

    logic [WIDTH-1:0] regFile_q [DEPTH];
    logic [WIDTH-1:0] rd0RegData;
    logic [WIDTH-1:0] rd1RegData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= WIDTH'(RF_RESET_VAL);
            end
        end else if (wr_en) begin
            regFile_q[wr_addr] <= wr_data;
        end
    end

    assign rd0RegData = regFile_q[rd0_addr];
    assign rd1RegData = regFile_q[rd1_addr];

    rf_rd_port #(.WIDTH(WIDTH), .AW(AW)) uPort0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (rd0_req),
        .addr_i    (rd0_addr),
        .ready_i   (rd0_ready),
        .regData_i (rd0RegData),
        .wrEn_i    (wr_en),
        .wrAddr_i  (wr_addr),
        .wrData_i  (wr_data),
        .gnt_o     (rd0_gnt),
        .valid_o   (rd0_valid),
        .data_o    (rd0_data)
    );

    rf_rd_port #(.WIDTH(WIDTH), .AW(AW)) uPort1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (rd1_req),
        .addr_i    (rd1_addr),
        .ready_i   (rd1_ready),
        .regData_i (rd1RegData),
        .wrEn_i    (wr_en),
        .wrAddr_i  (wr_addr),
        .wrData_i  (wr_data),
        .gnt_o     (rd1_gnt),
        .valid_o   (rd1_valid),
        .data_o    (rd1_data)
    );

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed self-checking bench for reg_file_rd with a per-port scoreboard.
module tb_reg_file_rd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd0_req, rd0_gnt, rd0_valid, rd0_ready;
    logic [2:0] rd0_addr;
    logic [7:0] rd0_data;
    logic       rd1_req, rd1_gnt, rd1_valid, rd1_ready;
    logic [2:0] rd1_addr;
    logic [7:0] rd1_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdlMem [8];
    logic       expValid0, expValid1;
    logic [7:0] expData0, expData1;
    logic [7:0] sbQ0 [$];
    logic [7:0] sbQ1 [$];

    reg_file_rd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd0_req   (rd0_req),
        .rd0_addr  (rd0_addr),
        .rd0_gnt   (rd0_gnt),
        .rd0_valid (rd0_valid),
        .rd0_data  (rd0_data),
        .rd0_ready (rd0_ready),
        .rd1_req   (rd1_req),
        .rd1_addr  (rd1_addr),
        .rd1_gnt   (rd1_gnt),
        .rd1_valid (rd1_valid),
        .rd1_data  (rd1_data),
        .rd1_ready (rd1_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mdlMem[i] = 8'h00;
        expValid0 = 1'b0;
        expValid1 = 1'b0;
        expData0  = 8'h00;
        expData1  = 8'h00;
        sbQ0.delete();
        sbQ1.delete();
    endtask

    task automatic checkPorts(input string tag);
        checkOutput({tag, "_valid0"}, {7'b0, rd0_valid}, {7'b0, expValid0});
        checkOutput({tag, "_data0"},  rd0_data, expData0);
        checkOutput({tag, "_valid1"}, {7'b0, rd1_valid}, {7'b0, expValid1});
        checkOutput({tag, "_data1"},  rd1_data, expData1);
    endtask

    // One clock cycle: drive at the falling edge, check grants, then check outputs after the rising edge.
    task automatic applyStimulus(input string tag,
                                 input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic q0, input logic [2:0] a0, input logic y0,
                                 input logic q1, input logic [2:0] a1, input logic y1);
        logic g0, g1;
        @(negedge clk);
        wr_en = we;  wr_addr = wa;  wr_data = wd;
        rd0_req = q0; rd0_addr = a0; rd0_ready = y0;
        rd1_req = q1; rd1_addr = a1; rd1_ready = y1;
        g0 = q0 && (!expValid0 || y0);
        g1 = q1 && (!expValid1 || y1);
        #1;
        checkOutput({tag, "_gnt0"}, {7'b0, rd0_gnt}, {7'b0, g0});
        checkOutput({tag, "_gnt1"}, {7'b0, rd1_gnt}, {7'b0, g1});
        if (g0) sbQ0.push_back((we && wa == a0) ? wd : mdlMem[a0]);
        if (g1) sbQ1.push_back((we && wa == a1) ? wd : mdlMem[a1]);
        @(posedge clk);
        #1;
        if (we) mdlMem[wa] = wd;
        if (g0) begin
            expValid0 = 1'b1;
            expData0  = sbQ0.pop_front();
        end else if (y0) begin
            expValid0 = 1'b0;
        end
        if (g1) begin
            expValid1 = 1'b1;
            expData1  = sbQ1.pop_front();
        end else if (y1) begin
            expValid1 = 1'b0;
        end
        checkPorts(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd0_addr = '0; rd0_ready = 1'b0;
        rd1_req = 1'b0; rd1_addr = '0; rd1_ready = 1'b0;
        resetModel();

        repeat (2) @(posedge clk);
        #1;
        checkPorts("reset");
        checkOutput("reset_gnt0", {7'b0, rd0_gnt}, 8'h00);
        checkOutput("reset_gnt1", {7'b0, rd1_gnt}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Every register reads back zero after reset, on both ports.
        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("rstread%0d", i), 1'b0, 3'd0, 8'h00,
                          1'b1, 3'(i), 1'b1, 1'b1, 3'(7 - i), 1'b1);
        applyStimulus("rstread_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        applyStimulus("wr_r3", 1'b1, 3'd3, 8'hB3, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
        applyStimulus("rd_r3", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b1);
        applyStimulus("rd_r3_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        applyStimulus("fwd_r5", 1'b1, 3'd5, 8'h45, 1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1);
        applyStimulus("fwd_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        applyStimulus("bp_rd_r3", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 1'b0);
        applyStimulus("bp_stall0", 1'b1, 3'd3, 8'h93, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0);
        applyStimulus("bp_stall1", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0);
        applyStimulus("bp_stall2", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0);
        applyStimulus("bp_release", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b1);
        applyStimulus("bp_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("fill%0d", i), 1'b1, 3'(i), 8'(8'h1E + i * 8'h23),
                          1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("stream%0d", i), 1'b0, 3'd0, 8'h00,
                          1'b1, 3'(i), 1'b1, 1'b0, 3'd0, 1'b1);
        applyStimulus("stream_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        applyStimulus("hold_wr_r3", 1'b1, 3'd3, 8'h93, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
        applyStimulus("hold_rd_r3", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1);
        applyStimulus("hold_stall", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkPorts("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("midrst_rd_r3", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b1);
        applyStimulus("midrst_drop", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_rd.md
# reg_file_rd

Eight-entry, 8-bit processor register bank with two independent ready/valid read ports. It is the read-side counterpart of the enabled-register write path: each entry loads on `wr_en`, as the existing enabled flip-flops do. Each read port returns registered data one cycle after a request is accepted, forwards a same-cycle write, and holds its result until the consumer (ALU operand latch) accepts it.

## Interface
- `WIDTH`, 8, data width of each register
- `DEPTH`, 8, number of registers
- `AW`, 3, address width; must equal clog2(`DEPTH`)

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write enable
- `wr_addr`  in  `AW`  write address
- `wr_data`  in  `WIDTH`  write data
- `rd0_req`  in  1  port 0 read request
- `rd0_addr`  in  `AW`  port 0 read address
- `rd0_gnt`  out  1  port 0 request accepted this cycle (combinational)
- `rd0_valid`  out  1  port 0 output data valid
- `rd0_data`  out  `WIDTH`  port 0 read data
- `rd0_ready`  in  1  port 0 consumer accepts data
- `rd1_*`  same set as port 0, for port 1

## Operation
- Storage: `DEPTH` x `WIDTH` registers. On a rising edge with `wr_en`=1, `reg[wr_addr]` <= `wr_data`. With `wr_en`=0, all registers hold.
- Per port, there is one output stage holding `valid` and `data`.
- Grant: `gnt` = `req` && (!`valid` || `ready`). This supports back-to-back reads at full rate when the consumer is always ready.
- On a rising edge with `gnt`=1: `valid` <= 1, and `data` <= (`wr_en` && `wr_addr`==`addr`) ? `wr_data` : `reg[addr]`. This is write-first forwarding.
- On a rising edge with `valid`=1, `ready`=1 and `req`=0: `valid` <= 0. `data` holds its last value.
- When `valid`=1 and `ready`=0, `data` and `valid` are frozen. A later write to the same address does not alter the held data, because the output is a snapshot.
- The two ports are fully independent. Both may read the same address in the same cycle, and both receive identical data.
- Read with no request: the port output is unchanged apart from the valid drop rule above.
- `addr` is only sampled when `gnt`=1. All `AW`-bit addresses are legal for `DEPTH`=8.

## Timing
- Reset (async assert, `rst_n`=0) sets:
  - all registers to 0
  - `rd*_valid` to 0
  - `rd*_data` to 0
  - `rd*_gnt` to 0, since `gnt` depends only on `req`/`valid`/`ready` and `req` must be low during reset; the output logic forces `gnt`=0 while `rst_n`=0.
- Reset deassertion is synchronised by the system. The first request is honoured on the first rising edge with `rst_n`=1.
- Read latency: request accepted at edge N, so `valid`=1 with data after edge N and through cycle N+1.
- Write-to-read: a write at edge N is visible to a request accepted at the same edge N, through forwarding.
- Reset mid-operation: any held output is dropped immediately (`valid`=0, `data`=0), independent of `clk`. Register contents are lost.
- No combinational path from `rd*_ready` to `rd*_data`. The only combinational path from `ready` is to `gnt`.

## Structure
- Package `reg_file_pkg` holds:
  - `WIDTH`, `DEPTH`, `AW` default constants
  - the register-zero reset value constant (0)
- Sub-module `rf_rd_port` is instantiated twice. It contains the output stage, the grant logic and the forwarding mux. Its inputs are the selected register value plus the write bus.
- The top level holds the storage array, write logic and the two `rf_rd_port` instances.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles -> both `valid`=0 and `data`=0. Read r0..r7 after release -> all return 8'h00.
- **Write then read:** write r3=8'hB3 at edge N, then request r3 on port 0 at edge N+1 with `ready`=1 -> `rd0_valid`=1 and `rd0_data`=8'hB3 after edge N+1. `valid` drops one cycle later if no new request arrives.
- **Forwarding:** in the same cycle, write r5=8'h45 and request r5 on both ports -> both ports return 8'h45 after that edge, and neither returns the old value 8'h00.
- **Backpressure:** port 1 reads r3 (8'hB3) with `rd1_ready`=0. Then write r3=8'h93, and assert `rd1_req` for r5 ->
  - `rd1_gnt`=0
  - `rd1_data` stays 8'hB3 for 3 cycles
  - raising `rd1_ready` then grants the r5 read, returning 8'h45 on the next edge.
- **Streaming:** port 0 reads r0..r7 on consecutive cycles with `ready`=1 -> 8 consecutive valid beats, with data matching the written values and no bubbles.
- **Reset mid-hold:** with port 0 holding 8'h93 and `ready`=0, pulse `rst_n` low asynchronously between edges -> `rd0_valid`=0 and `rd0_data`=8'h00 immediately. A subsequent read of r3 returns 8'h00.
